// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first word adder with valid/ready in and out
// Define SERIAL_ADDER_CIN_EN to add the in_cin carry-in port (sampled on accept).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             in_cin,
`endif
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_sh, b_sh, sum_q;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic              cin0;
  logic              p, g, s, c_nxt;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin0 = in_cin;
`else
  assign cin0 = 1'b0;
`endif

  // Full adder built from two half-adder stages: (a,b) -> (p,g), then (p,carry).
  assign p     = a_sh[0] ^ b_sh[0];
  assign g     = a_sh[0] & b_sh[0];
  assign s     = p ^ carry;
  assign c_nxt = g | (p & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (o_ready)      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum_q <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= in_a;
          b_sh  <= in_b;
          sum_q <= '0;
          cnt   <= '0;
          carry <= cin0;
        end
        RUN: begin
          // Operands shift right so bit i is always at position 0; sum fills from the MSB.
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_q <= {s, sum_q[WIDTH-1:1]};
          carry <= c_nxt;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_sum    = sum_q;
  assign o_carry  = carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (honours SERIAL_ADDER_CIN_EN)
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_sum;
  logic         o_carry;

  int checks;
  int errors;
  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef SERIAL_ADDER_CIN_EN
    .in_cin   (in_cin),
`endif
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_sum    (o_sum),
    .o_carry  (o_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one pop per output transfer (o_valid && o_ready seen before the edge).
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", {o_carry, o_sum});
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("sum", 32'(o_sum), 32'(e[W-1:0]));
        chk("carry", 32'(o_carry), 32'(e[W]));
      end
    end
  end

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[W:0];
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  // Issues one operation; hold = cycles o_ready stays low in DONE; toggle = noise on inputs during RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int hold, input bit toggle);
    logic [W:0] e;
    wait_ready();
    e        = model(a, b, c);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    o_ready  = (hold == 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    chk("in_ready_run", 32'(in_ready), 32'd0);
    for (int k = 1; k <= W; k++) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
      end
      @(posedge clk); #1;
      chk("o_valid_latency", 32'(o_valid), (k == W) ? 32'd1 : 32'd0);
    end
    in_valid = (hold > 0);
    in_a     = ~a;
    in_b     = ~b;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_sum", 32'(o_sum), 32'(e[W-1:0]));
      chk("hold_carry", 32'(o_carry), 32'(e[W]));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    o_ready  = 1'b1;
    @(posedge clk); #1;
    chk("idle_o_valid", 32'(o_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    o_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_sum", 32'(o_sum), 32'd0);
    chk("rst_o_carry", 32'(o_carry), 32'd0);
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h5A, 8'hA5, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 3, 1'b0);
    do_op(8'h37, 8'hC4, 1'b0, 0, 1'b1);

    // Reset four bits into 0x0F+0x01; the pending result must vanish.
    wait_ready();
    in_a     = 8'h0F;
    in_b     = 8'h01;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o_sum", 32'(o_sum), 32'd0);
    chk("midrst_o_carry", 32'(o_carry), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h10, 8'h10, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_CIN_EN
    do_op(8'hFF, 8'h00, 1'b1, 0, 1'b0);
    do_op(8'h01, 8'h01, 1'b1, 1, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic c;
`ifdef SERIAL_ADDER_CIN_EN
      c = 1'($urandom);
`else
      c = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), c, int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
